// File: rtl/decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan_sequencer
// Purpose  : Steps a 3-to-8 decoder through its unmasked addresses, holding
//            each for dwell+1 cycles with a one-cycle enable gap between them.
// Revision : 1.0
// ============================================================================
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         skip_mask,
  output logic               A0,
  output logic               A1,
  output logic               A2,
  output logic               enable,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           addr_q, addr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [7:0]           mask_q, mask_d;
  logic                 enable_q, busy_q, done_q;
  logic                 enable_d, busy_d, done_d;
  logic [2:0]           w_cfg_first;
  logic [2:0]           w_in_first;
  logic [3:0]           w_next;

  function automatic logic [2:0] lowest_clear(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Returns {found, index} of the lowest unmasked address at or above lo.
  function automatic logic [3:0] clear_from(input logic [7:0] m, input int lo);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i >= lo && !m[i]) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

  assign w_cfg_first = lowest_clear(mask_q);
  assign w_in_first  = lowest_clear(skip_mask);
  assign w_next      = clear_from(mask_q, int'(addr_q) + 1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        addr_d = 3'd0;
        cnt_d  = '0;
        if (start && !stop) begin
          mode_d  = mode;
          dwell_d = dwell;
          mask_d  = skip_mask;
          if (skip_mask == 8'hFF) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            addr_d  = w_in_first;
            cnt_d   = dwell;
          end
        end
      end
      S_SCAN: begin
        if (stop) begin
          state_d = S_IDLE;
          addr_d  = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          if (w_next[3]) begin
            state_d = S_GAP;
            addr_d  = w_next[2:0];
          end else if (mode_q) begin
            state_d = S_GAP;
            addr_d  = w_cfg_first;
          end else begin
            state_d = S_DONE;
            addr_d  = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          addr_d  = 3'd0;
          cnt_d   = '0;
        end else begin
          state_d = S_SCAN;
          cnt_d   = dwell_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    enable_d = (state_d == S_SCAN);
    busy_d   = (state_d == S_SCAN) || (state_d == S_GAP);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= 3'd0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      dwell_q  <= '0;
      mask_q   <= 8'd0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
      mask_q   <= mask_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign A0     = addr_q[0];
  assign A1     = addr_q[1];
  assign A2     = addr_q[2];
  assign enable = enable_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_scan_sequencer
// Purpose  : Self-checking bench for decoder_scan_sequencer.
// Revision : 1.0
// ============================================================================
module tb_decoder_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, mode;
  logic [7:0] dwell, skip_mask;
  logic       A0, A1, A2, enable, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected per-cycle outputs packed as {addr[2:0], enable, busy, done}.
  logic [5:0] exp_q[$];

  typedef struct {
    logic       m;
    logic [7:0] d;
    logic [7:0] k;
    int         busy_n;
    int         en_n;
    int         done_n;
    logic [2:0] first;
  } vec_t;

  vec_t vt[7];

  always #5 clk = ~clk;

  decoder_scan_sequencer #(.DWELL_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dwell     (dwell),
    .skip_mask (skip_mask),
    .A0        (A0),
    .A1        (A1),
    .A2        (A2),
    .enable    (enable),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [5:0] outs();
    return {A2, A1, A0, enable, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got addr=%0d en=%b busy=%b done=%b, want addr=%0d en=%b busy=%b done=%b",
               nm, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Reference trace: list the unmasked addresses, hold each dwell+1 cycles,
  // put one gap cycle (showing the next address) between neighbours.
  task automatic fill_exp(input logic m, input logic [7:0] d, input logic [7:0] k, input int cap);
    int lst[$];
    int pos;
    exp_q.delete();
    for (int i = 0; i < 8; i++) if (!k[i]) lst.push_back(i);
    if (lst.size() == 0) begin
      exp_q.push_back(6'b000_001);
      return;
    end
    pos = 0;
    while (exp_q.size() < cap) begin
      for (int c = 0; c <= int'(d); c++) exp_q.push_back({3'(lst[pos]), 3'b110});
      if (pos + 1 < lst.size()) begin
        pos++;
        exp_q.push_back({3'(lst[pos]), 3'b010});
      end else if (m) begin
        pos = 0;
        exp_q.push_back({3'(lst[pos]), 3'b010});
      end else begin
        exp_q.push_back(6'b000_001);
        break;
      end
    end
  endtask

  // Runs one scan against the model; stop goes high in the cycle after
  // output index stop_at (negative = never). Start is randomly re-pulsed and
  // config inputs scrambled while the scan is active.
  task automatic run_check(input logic m, input logic [7:0] d, input logic [7:0] k,
                           input int stop_at, input string nm);
    int n;
    logic [5:0] e;
    fill_exp(m, d, k, 200);
    n = exp_q.size();
    if (stop_at >= 0 && stop_at + 1 < n) n = stop_at + 1;
    mode = m; dwell = d; skip_mask = k; start = 1'b1; stop = 1'b0;
    for (int t = 0; t < n + 3; t++) begin
      tick();
      if (t == 0) begin
        mode = $urandom % 2; dwell = 8'($urandom); skip_mask = 8'($urandom);
      end
      e = (t < n) ? exp_q[t] : 6'd0;
      chk($sformatf("%s t=%0d", nm, t), outs(), e);
      stop  = (t == stop_at);
      start = (t < n) ? 1'($urandom % 2) : 1'b0;
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    int b, en_n, dn, bad;
    logic [2:0] first, a;
    logic seen;
    logic m;
    logic [7:0] d, k;
    int sa;

    vt[0] = '{1'b0, 8'd0, 8'h00, 15, 8, 1, 3'd0};
    vt[1] = '{1'b0, 8'd2, 8'hAA, 15, 12, 1, 3'd0};
    vt[2] = '{1'b0, 8'd0, 8'hFF, 0, 0, 1, 3'd0};
    vt[3] = '{1'b0, 8'd3, 8'h7F, 4, 4, 1, 3'd7};
    vt[4] = '{1'b0, 8'd1, 8'h0F, 11, 8, 1, 3'd4};
    vt[5] = '{1'b0, 8'd0, 8'hFE, 1, 1, 1, 3'd0};
    vt[6] = '{1'b0, 8'd0, 8'h5A, 7, 4, 1, 3'd0};

    // Reset held with start high: nothing may begin.
    reset = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b1; dwell = 8'd0; skip_mask = 8'h00;
    tick(); chk("reset c1", outs(), 6'd0);
    tick(); chk("reset c2", outs(), 6'd0);
    reset = 1'b0; start = 1'b0;
    tick(); chk("post reset idle", outs(), 6'd0);

    // Start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    tick(); chk("start+stop idle", outs(), 6'd0);
    start = 1'b0; stop = 1'b0;
    tick(); chk("start+stop idle2", outs(), 6'd0);

    // Table of one-shot passes checked by summary counts.
    for (int i = 0; i < 7; i++) begin
      mode = vt[i].m; dwell = vt[i].d; skip_mask = vt[i].k; start = 1'b1;
      tick();
      start = 1'b0;
      b = 0; en_n = 0; dn = 0; bad = 0; first = 3'd0; seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
        a = {A2, A1, A0};
        if (busy) b++;
        if (enable) begin
          en_n++;
          if (!seen) first = a;
          seen = 1'b1;
          if (vt[i].k[a]) bad++;
        end
        if (done) dn++;
        if (!busy && !done) break;
        tick();
      end
      chk_int($sformatf("vec%0d busy cycles", i), b, vt[i].busy_n);
      chk_int($sformatf("vec%0d enable cycles", i), en_n, vt[i].en_n);
      chk_int($sformatf("vec%0d done pulses", i), dn, vt[i].done_n);
      chk_int($sformatf("vec%0d first addr", i), int'(first), int'(vt[i].first));
      chk_int($sformatf("vec%0d masked enables", i), bad, 0);
      tick(); chk($sformatf("vec%0d idle after", i), outs(), 6'd0);
    end

    // Model-checked directed scans.
    run_check(1'b0, 8'd0, 8'h00, -1, "full_pass");
    run_check(1'b1, 8'd2, 8'hAA, 40, "cont_AA");
    run_check(1'b1, 8'd1, 8'hEF, 15, "cont_single");

    // All masked: done right after the sampling edge, exactly one cycle.
    mode = 1'b1; dwell = 8'd3; skip_mask = 8'hFF; start = 1'b1;
    tick(); start = 1'b0; chk("allmask done", outs(), 6'b000_001);
    tick(); chk("allmask idle1", outs(), 6'd0);
    tick(); chk("allmask idle2", outs(), 6'd0);

    // Stop on the third dwell cycle of address 1.
    mode = 1'b0; dwell = 8'd5; skip_mask = 8'h00; start = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick(); start = 1'b0;
      chk($sformatf("stopdw t=%0d", t), outs(),
          (t < 6) ? 6'b000_110 : ((t == 6) ? 6'b001_010 : 6'b001_110));
    end
    stop = 1'b1;
    tick(); stop = 1'b0; chk("stopdw halted", outs(), 6'd0);
    tick(); chk("stopdw no done", outs(), 6'd0);

    // Start while busy is ignored, reset during GAP, then restart.
    mode = 1'b0; dwell = 8'd1; skip_mask = 8'h01; start = 1'b1;
    tick(); chk("busy start t0", outs(), 6'b001_110);
    start = 1'b1; dwell = 8'd5; skip_mask = 8'h00;
    tick(); chk("busy start t1", outs(), 6'b001_110);
    start = 1'b0;
    tick(); chk("busy start gap", outs(), 6'b010_010);
    reset = 1'b1;
    tick(); chk("reset in gap", outs(), 6'd0);
    reset = 1'b0;
    tick(); chk("reset in gap idle", outs(), 6'd0);
    mode = 1'b0; dwell = 8'd0; skip_mask = 8'h03; start = 1'b1;
    tick(); start = 1'b0; chk("restart first", outs(), 6'b010_110);
    tick(); chk("restart gap", outs(), 6'b011_010);
    stop = 1'b1;
    tick(); stop = 1'b0; chk("restart stop", outs(), 6'd0);

    // Reset on the cycle that would have been DONE suppresses the pulse.
    mode = 1'b0; dwell = 8'd0; skip_mask = 8'h7F; start = 1'b1;
    tick(); start = 1'b0; chk("rst done scan", outs(), 6'b111_110);
    reset = 1'b1;
    tick(); reset = 1'b0; chk("rst done suppressed", outs(), 6'd0);
    tick(); chk("rst done idle", outs(), 6'd0);

    // Randomized scans against the reference model.
    for (int r = 0; r < 25; r++) begin
      m = 1'($urandom % 2);
      d = 8'($urandom_range(0, 4));
      case ($urandom % 8)
        0: k = 8'hFF;
        1: k = 8'hFF ^ (8'd1 << $urandom_range(0, 7));
        default: k = 8'($urandom);
      endcase
      if (m) sa = $urandom_range(0, 60);
      else sa = ($urandom % 2) ? -1 : int'($urandom_range(0, 40));
      run_check(m, d, k, sa, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
